// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of a single-port synchronous RAM
//
// Purpose
//   Serialises RAM accesses from two requesters (bit 0 = CPU, bit 1 = loader/debug).
//   Each transaction is IDLE sample -> ACCESS (one cycle) -> optional WAIT_RD
//   (RD_LAT cycles) -> IDLE. All outputs are registered.
//
// Parameters
//   ADDR_W   RAM word address width
//   DATA_W   RAM data width
//   RD_LAT   RAM read latency, address cycle to valid ram_rdata (1..4)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   req[1:0]   in   per-requester request, held until gnt is seen
//   we[1:0]    in   per-requester write(1)/read(0)
//   addr       in   2*ADDR_W, requester k uses [k*ADDR_W +: ADDR_W]
//   wdata      in   2*DATA_W, requester k uses [k*DATA_W +: DATA_W]
//   gnt[1:0]   out  one-cycle grant pulse during ACCESS
//   rvalid     out  one-cycle read-data-valid pulse
//   rdata      out  read data, holds until the next capture
//   ram_addr   out  RAM address
//   ram_wdata  out  RAM write data
//   ram_we     out  RAM write strobe
//   ram_rdata  in   RAM read data
//   busy       out  high during ACCESS and WAIT_RD
//
// Build option
//   MEM_ARB_RR_EN  defined: round-robin tie break using last_winner;
//                  undefined: fixed priority, requester 0 wins ties.

module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req,
   input  logic [1:0]          we,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [1:0]          gnt,
   output logic [1:0]          rvalid,
   output logic [DATA_W-1:0]   rdata,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   output logic                ram_we,
   input  logic [DATA_W-1:0]   ram_rdata,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_WAIT_RD = 2'd2
   } state_t;

   // The down-counter is loaded with RD_LAT-1 so that zero marks the last WAIT_RD cycle.
   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

   state_t              state, state_nxt;
   logic                win, win_nxt;          // latched winner index
   logic                lat_we, lat_we_nxt;    // latched write select of the winner
   logic [1:0]          lat_cnt, lat_cnt_nxt;
   logic [1:0]          gnt_nxt;
   logic [1:0]          rvalid_nxt;
   logic [DATA_W-1:0]   rdata_nxt;
   logic [ADDR_W-1:0]   ram_addr_nxt;
   logic [DATA_W-1:0]   ram_wdata_nxt;
   logic                ram_we_nxt;
   logic                busy_nxt;
   logic                pick;                  // winner among the currently asserted requests

`ifdef MEM_ARB_RR_EN
   logic                last_winner, last_winner_nxt;

   // A tie goes to whoever did not win last; a lone request simply wins.
   always_comb begin
      if (req == 2'b11) begin
         pick = ~last_winner;
      end else begin
         pick = ~req[0];
      end
   end
`else
   // Requester 0 wins whenever it asks; pick is only used when some req bit is set.
   assign pick = ~req[0];
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      win_nxt       = win;
      lat_we_nxt    = lat_we;
      lat_cnt_nxt   = lat_cnt;
      gnt_nxt       = 2'b00;
      rvalid_nxt    = 2'b00;
      rdata_nxt     = rdata;
      ram_addr_nxt  = ram_addr;
      ram_wdata_nxt = ram_wdata;
      ram_we_nxt    = 1'b0;
      busy_nxt      = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_winner_nxt = last_winner;
`endif

      case (state)
         ST_IDLE: begin
            if (req != 2'b00) begin
               // Latch the winner's command straight into the RAM-side registers,
               // so later changes on the requester inputs cannot disturb it.
               state_nxt     = ST_ACCESS;
               win_nxt       = pick;
               lat_we_nxt    = we[pick];
               ram_addr_nxt  = pick ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
               ram_wdata_nxt = pick ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
               ram_we_nxt    = we[pick];
               gnt_nxt       = pick ? 2'b10 : 2'b01;
               busy_nxt      = 1'b1;
`ifdef MEM_ARB_RR_EN
               last_winner_nxt = pick;
`endif
            end
         end

         ST_ACCESS: begin
            if (lat_we) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt   = ST_WAIT_RD;
               lat_cnt_nxt = LAT_LOAD;
               busy_nxt    = 1'b1;
            end
         end

         ST_WAIT_RD: begin
            // ram_addr is not touched here, so it stays stable for the whole wait.
            if (lat_cnt == 2'd0) begin
               state_nxt  = ST_IDLE;
               rdata_nxt  = ram_rdata;
               rvalid_nxt = win ? 2'b10 : 2'b01;
            end else begin
               lat_cnt_nxt = lat_cnt - 2'd1;
               busy_nxt    = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         win       <= 1'b0;
         lat_we    <= 1'b0;
         lat_cnt   <= 2'd0;
         gnt       <= 2'b00;
         rvalid    <= 2'b00;
         rdata     <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         // Reset to 1 so requester 0 takes the first tie.
         last_winner <= 1'b1;
`endif
      end else begin
         state     <= state_nxt;
         win       <= win_nxt;
         lat_we    <= lat_we_nxt;
         lat_cnt   <= lat_cnt_nxt;
         gnt       <= gnt_nxt;
         rvalid    <= rvalid_nxt;
         rdata     <= rdata_nxt;
         ram_addr  <= ram_addr_nxt;
         ram_wdata <= ram_wdata_nxt;
         ram_we    <= ram_we_nxt;
         busy      <= busy_nxt;
`ifdef MEM_ARB_RR_EN
         last_winner <= last_winner_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter, RD_LAT 1..4 side by side

module tb_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int NI = 4;   // instance i has RD_LAT = i+1

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [1:0]          req_a [NI];
   logic [1:0]          we_a [NI];
   logic [2*AW-1:0]     addr_a [NI];
   logic [2*DW-1:0]     wdata_a [NI];
   logic [1:0]          gnt_a [NI];
   logic [1:0]          rvalid_a [NI];
   logic [DW-1:0]       rdata_a [NI];
   logic [AW-1:0]       ram_addr_a [NI];
   logic [DW-1:0]       ram_wdata_a [NI];
   logic                ram_we_a [NI];
   logic [DW-1:0]       ram_rdata_a [NI];
   logic                busy_a [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g + 1)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req       (req_a[g]),
         .we        (we_a[g]),
         .addr      (addr_a[g]),
         .wdata     (wdata_a[g]),
         .gnt       (gnt_a[g]),
         .rvalid    (rvalid_a[g]),
         .rdata     (rdata_a[g]),
         .ram_addr  (ram_addr_a[g]),
         .ram_wdata (ram_wdata_a[g]),
         .ram_we    (ram_we_a[g]),
         .ram_rdata (ram_rdata_a[g]),
         .busy      (busy_a[g])
      );
   end

   function automatic logic [DW-1:0] init_word(int i, int j);
      return DW'(i * 4096 + j * 257 + 5);
   endfunction

   // Behavioural RAMs: data is only valid exactly RD_LAT cycles after a read address cycle.
   logic [DW-1:0] ram_m [NI][32];
   logic [DW-1:0] pipe [NI][4];
   logic          pv [NI][4];
   logic [DW-1:0] junk;
   logic          ram_inited = 1'b0;

   always @(posedge clk) begin
      junk <= DW'($urandom);
      for (int i = 0; i < NI; i++) begin
         if (!ram_inited) begin
            for (int j = 0; j < 32; j++) ram_m[i][j] <= init_word(i, j);
         end else if (ram_we_a[i]) begin
            ram_m[i][ram_addr_a[i]] <= ram_wdata_a[i];
         end
         pipe[i][0] <= ram_m[i][ram_addr_a[i]];
         pv[i][0]   <= (gnt_a[i] != 2'b00) && !ram_we_a[i];
         for (int j = 1; j < 4; j++) begin
            pipe[i][j] <= pipe[i][j-1];
            pv[i][j]   <= pv[i][j-1];
         end
      end
      ram_inited <= 1'b1;
   end

   always_comb begin
      for (int i = 0; i < NI; i++) ram_rdata_a[i] = pv[i][i] ? pipe[i][i] : junk;
   end

   // Transaction-level reference model.
   int            t;
   int            checks;
   int            failures;
   logic          started [NI];
   logic          act [NI];
   int            s_c [NI];
   logic          m_win [NI];
   logic          m_wr [NI];
   logic [AW-1:0] m_a [NI];
   logic [DW-1:0] m_d [NI];
   logic [DW-1:0] m_rv [NI];
   logic [DW-1:0] m_lrd [NI];
   int            free_at [NI];
   int            rst_chk [NI];
   logic [DW-1:0] mmem [NI][32];
   logic [1:0]    seen_gnt [NI];
   logic [1:0]    pend [NI];
`ifdef MEM_ARB_RR_EN
   logic          m_lw [NI];
`endif

   task automatic chk(string name, int i, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h", name, i, t, got, exp);
      end
   endtask

   task automatic model_check(int i);
      logic [1:0] eg, ev;
      logic       eb, ewe;
      int         lat;
      lat = i + 1;
      seen_gnt[i] = gnt_a[i];
      if (!started[i]) return;
      eg = 2'b00; ev = 2'b00; eb = 1'b0; ewe = 1'b0;
      if (act[i]) begin
         if (t == s_c[i] + 1) begin
            eg  = m_win[i] ? 2'b10 : 2'b01;
            eb  = 1'b1;
            ewe = m_wr[i];
         end else if (!m_wr[i] && t >= s_c[i] + 2 && t <= s_c[i] + 1 + lat) begin
            eb = 1'b1;
         end
         if (!m_wr[i] && t == s_c[i] + 2 + lat) begin
            ev       = m_win[i] ? 2'b10 : 2'b01;
            m_lrd[i] = m_rv[i];
         end
      end
      chk("gnt", i, gnt_a[i], eg);
      chk("rvalid", i, rvalid_a[i], ev);
      chk("busy", i, busy_a[i], eb);
      chk("ram_we", i, ram_we_a[i], ewe);
      chk("rdata", i, rdata_a[i], m_lrd[i]);
      if (eb) chk("ram_addr", i, ram_addr_a[i], m_a[i]);
      if (ewe) chk("ram_wdata", i, ram_wdata_a[i], m_d[i]);
      if (t == rst_chk[i]) begin
         chk("rst_ram_addr", i, ram_addr_a[i], 0);
         chk("rst_ram_wdata", i, ram_wdata_a[i], 0);
      end
   endtask

   task automatic model_decide(int i);
      logic w;
      int   lat;
      lat = i + 1;
      if (!rst_n) begin
         started[i] = 1'b1;
         act[i]     = 1'b0;
         m_lrd[i]   = '0;
         free_at[i] = t + 1;
         rst_chk[i] = t + 1;
`ifdef MEM_ARB_RR_EN
         m_lw[i] = 1'b1;
`endif
      end else if (started[i] && t >= free_at[i] && req_a[i] != 2'b00) begin
         if (req_a[i] == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            w = !m_lw[i];
`else
            w = 1'b0;
`endif
         end else begin
            w = req_a[i][1];
         end
`ifdef MEM_ARB_RR_EN
         m_lw[i] = w;
`endif
         act[i]   = 1'b1;
         s_c[i]   = t;
         m_win[i] = w;
         m_wr[i]  = we_a[i][w];
         m_a[i]   = w ? addr_a[i][2*AW-1:AW] : addr_a[i][AW-1:0];
         m_d[i]   = w ? wdata_a[i][2*DW-1:DW] : wdata_a[i][DW-1:0];
         if (m_wr[i]) begin
            mmem[i][m_a[i]] = m_d[i];
            free_at[i] = t + 2;
         end else begin
            m_rv[i] = mmem[i][m_a[i]];
            free_at[i] = t + 2 + lat;
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         model_check(i);
         model_decide(i);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic tick();
      sample();
      advance();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < NI; i++) req_a[i] = 2'b00;
      repeat (n) tick();
   endtask

   task automatic agents();
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (seen_gnt[i][k]) pend[i][k] = 1'b0;
            if (!pend[i][k]) begin
               we_a[i][k]              = 1'($urandom);
               addr_a[i][k*AW +: AW]   = AW'($urandom_range(0, 7));
               wdata_a[i][k*DW +: DW]  = DW'($urandom);
               if ($urandom_range(0, 99) < 30) pend[i][k] = 1'b1;
            end
            req_a[i][k] = pend[i][k];
         end
      end
   endtask

   typedef struct {
      int            inst;
      logic [1:0]    req;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    e_gnt;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [1:0]    e_rv;
      logic [DW-1:0] e_rd;
   } vec_t;

   vec_t       tv [8];
   logic [1:0] arb_exp [4];

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", t);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int i;
      int lat;

      tv[0] = '{0, 2'b01, 2'b01, 5'h03, 5'h00, 16'hBEEF, 16'h0000, 2'b01, 1'b1, 5'h03, 16'hBEEF, 2'b00, 16'h0000};
      tv[1] = '{1, 2'b10, 2'b10, 5'h00, 5'h1F, 16'h0000, 16'h1234, 2'b10, 1'b1, 5'h1F, 16'h1234, 2'b00, 16'h0000};
      tv[2] = '{1, 2'b10, 2'b00, 5'h00, 5'h1F, 16'h0000, 16'h0000, 2'b10, 1'b0, 5'h1F, 16'h0000, 2'b10, 16'h1234};
      tv[3] = '{0, 2'b10, 2'b00, 5'h00, 5'h03, 16'h0000, 16'h0000, 2'b10, 1'b0, 5'h03, 16'h0000, 2'b10, 16'hBEEF};
      tv[4] = '{3, 2'b01, 2'b01, 5'h00, 5'h00, 16'h0001, 16'h0000, 2'b01, 1'b1, 5'h00, 16'h0001, 2'b00, 16'h0000};
      tv[5] = '{3, 2'b01, 2'b00, 5'h00, 5'h00, 16'h0000, 16'h0000, 2'b01, 1'b0, 5'h00, 16'h0000, 2'b01, 16'h0001};
      tv[6] = '{2, 2'b01, 2'b01, 5'h1F, 5'h00, 16'hFFFF, 16'h0000, 2'b01, 1'b1, 5'h1F, 16'hFFFF, 2'b00, 16'h0000};
      tv[7] = '{2, 2'b01, 2'b00, 5'h1F, 5'h00, 16'h0000, 16'h0000, 2'b01, 1'b0, 5'h1F, 16'h0000, 2'b01, 16'hFFFF};
`ifdef MEM_ARB_RR_EN
      arb_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      arb_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

      checks = 0;
      failures = 0;
      t = 0;
      rst_n = 1'b0;
      for (int k = 0; k < NI; k++) begin
         req_a[k] = 2'b00; we_a[k] = 2'b00; addr_a[k] = '0; wdata_a[k] = '0;
         started[k] = 1'b0; act[k] = 1'b0; s_c[k] = 0; free_at[k] = 0; rst_chk[k] = -1;
         m_lrd[k] = '0; seen_gnt[k] = 2'b00; pend[k] = 2'b00;
         for (int j = 0; j < 32; j++) mmem[k][j] = init_word(k, j);
      end

      // Reset, then the reset state of every instance.
      @(posedge clk);
      #1;
      repeat (3) tick();
      rst_n = 1'b1;
      sample();
      for (int k = 0; k < NI; k++) begin
         chk("reset_gnt", k, gnt_a[k], 0);
         chk("reset_rvalid", k, rvalid_a[k], 0);
         chk("reset_busy", k, busy_a[k], 0);
         chk("reset_ram_we", k, ram_we_a[k], 0);
         chk("reset_rdata", k, rdata_a[k], 0);
      end
      advance();

      // Single-transaction vectors.
      for (int v = 0; v < 8; v++) begin
         idle(8);
         i = tv[v].inst;
         lat = i + 1;
         req_a[i]   = tv[v].req;
         we_a[i]    = tv[v].we;
         addr_a[i]  = {tv[v].a1, tv[v].a0};
         wdata_a[i] = {tv[v].d1, tv[v].d0};
         tick();
         sample();
         chk("tv_gnt", i, gnt_a[i], tv[v].e_gnt);
         chk("tv_ram_we", i, ram_we_a[i], tv[v].e_we);
         chk("tv_ram_addr", i, ram_addr_a[i], tv[v].e_addr);
         if (tv[v].e_we) chk("tv_ram_wdata", i, ram_wdata_a[i], tv[v].e_wdata);
         advance();
         req_a[i] = 2'b00;
         if (tv[v].e_we) begin
            sample();
            chk("tv_idle_after_wr", i, busy_a[i], 0);
            advance();
         end else begin
            repeat (lat) tick();
            sample();
            chk("tv_rvalid", i, rvalid_a[i], tv[v].e_rv);
            chk("tv_rdata", i, rdata_a[i], tv[v].e_rd);
            advance();
         end
      end

      // Both requesters held high for four writes, starting right after reset.
      idle(8);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_a[0]   = 2'b11;
      we_a[0]    = 2'b11;
      addr_a[0]  = {5'h02, 5'h01};
      wdata_a[0] = {16'h2222, 16'h1111};
      for (int c = 0; c < 8; c++) begin
         sample();
         if (c % 2 == 1) chk("arb_gnt", 0, gnt_a[0], arb_exp[c / 2]);
         else chk("arb_gnt_gap", 0, gnt_a[0], 0);
         advance();
      end
      req_a[0] = 2'b00;

      // Reset during WAIT_RD of a RD_LAT=3 read: no rvalid afterwards.
      idle(8);
      req_a[2]  = 2'b01;
      we_a[2]   = 2'b00;
      addr_a[2] = {5'h00, 5'h05};
      tick();
      sample();
      chk("abort_rd_gnt", 2, gnt_a[2], 2'b01);
      advance();
      req_a[2] = 2'b00;
      rst_n = 1'b0;
      sample();
      chk("abort_rd_busy_pre", 2, busy_a[2], 1);
      advance();
      rst_n = 1'b1;
      sample();
      chk("abort_rd_busy", 2, busy_a[2], 0);
      chk("abort_rd_ram_we", 2, ram_we_a[2], 0);
      chk("abort_rd_rdata", 2, rdata_a[2], 0);
      advance();
      for (int c = 0; c < 7; c++) begin
         sample();
         chk("abort_rd_rvalid", 2, rvalid_a[2], 0);
         advance();
      end

      // Reset during ACCESS of a write: strobe drops on the next cycle.
      idle(8);
      req_a[1]   = 2'b10;
      we_a[1]    = 2'b10;
      addr_a[1]  = {5'h09, 5'h00};
      wdata_a[1] = {16'h9999, 16'h0000};
      tick();
      req_a[1] = 2'b00;
      rst_n = 1'b0;
      sample();
      chk("abort_wr_gnt", 1, gnt_a[1], 2'b10);
      chk("abort_wr_we_pre", 1, ram_we_a[1], 1);
      advance();
      rst_n = 1'b1;
      sample();
      chk("abort_wr_we", 1, ram_we_a[1], 0);
      chk("abort_wr_busy", 1, busy_a[1], 0);
      advance();

      // Request from requester 1 arriving during requester 0's RD_LAT=1 read.
      idle(8);
      req_a[0]   = 2'b01;
      we_a[0]    = 2'b00;
      addr_a[0]  = {5'h00, 5'h03};
      wdata_a[0] = '0;
      tick();
      sample();
      chk("late_gnt0", 0, gnt_a[0], 2'b01);
      advance();
      req_a[0]   = 2'b10;
      we_a[0]    = 2'b10;
      addr_a[0]  = {5'h07, 5'h03};
      wdata_a[0] = {16'h7777, 16'h0000};
      sample();
      chk("late_busy", 0, busy_a[0], 1);
      advance();
      sample();
      chk("late_rvalid", 0, rvalid_a[0], 2'b01);
      chk("late_rdata", 0, rdata_a[0], 16'hBEEF);
      chk("late_no_gnt", 0, gnt_a[0], 2'b00);
      advance();
      sample();
      chk("late_gnt1", 0, gnt_a[0], 2'b10);
      chk("late_ram_addr", 0, ram_addr_a[0], 5'h07);
      chk("late_ram_wdata", 0, ram_wdata_a[0], 16'h7777);
      advance();
      req_a[0] = 2'b00;

      // Randomised traffic with occasional resets, checked by the model every cycle.
      idle(8);
      for (int k = 0; k < NI; k++) pend[k] = 2'b00;
      for (int c = 0; c < 4000; c++) begin
         agents();
         rst_n = ($urandom_range(0, 249) != 0);
         tick();
      end
      rst_n = 1'b1;
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
